multicycle_controller: RTL and testbench

Moore-style sequencing FSM that drives a multicycle build of the 32-bit MIPS datapath. It uses the same shared register file, ALU, sign-extend and memory blocks, with one shared instruction/data memory port. It decodes Opcode/Func from the instruction register and steps each instruction through fetch, decode, execute, memory and writeback. It also supplies ALU, mux and write-enable controls, a memory wait handshake, a retire counter and an illegal-instruction flag.

---
 rtl/mips_mc_pkg.sv | 65 ++++++
 rtl/alu_decoder.sv | 30 +++
 rtl/multicycle_controller.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// R-type function codes, ALU operations and datapath mux selects.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_RTEX    = 4'd6,
        ST_RTWB    = 4'd7,
        ST_BEQEX   = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_ADDIWB  = 4'd10,
        ST_JEX     = 4'd11,
        ST_ILLEGAL = 4'd12
    } state_e;

    // Operation class handed to the ALU decoder; FUNC defers to the Func field.
    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'd0,
        ALUOP_SUB  = 2'd1,
        ALUOP_FUNC = 2'd2
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic rtype_func_legal(input logic [5:0] fn);
        logic ok;
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an operation class plus the R-type Func field onto the ALU control code.
// Unknown Func values fall back to add; the FSM never executes them anyway.
module alu_decoder
    import mips_mc_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [5:0] func_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNC: begin
                case (func_i)
                    FN_ADD:  alu_control_o = ALU_ADD;
                    FN_SUB:  alu_control_o = ALU_SUB;
                    FN_AND:  alu_control_o = ALU_AND;
                    FN_OR:   alu_control_o = ALU_OR;
                    FN_SLT:  alu_control_o = ALU_SLT;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle MIPS datapath, with a memory wait
// handshake, a retired-instruction counter and an illegal-instruction pulse.
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE  | precompute branch target, dispatch on opcode
// MEMADR  | compute lw/sw effective address
// MEMRD   | read data memory, wait for Mem_Ready
// MEMWB   | write loaded word to rt
// MEMWR   | write data memory, held until Mem_Ready
// RTEX    | R-type ALU operation
// RTWB    | write ALU result to rd
// BEQEX   | compare and conditionally take branch
// ADDIEX  | add immediate
// ADDIWB  | write ALU result to rt
// JEX     | load jump target into PC
// ILLEGAL | skip unsupported instruction, flag it
module multicycle_controller
    import mips_mc_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Func,
    input  logic        Zero,
    input  logic        Mem_Ready,
    output logic        PCEn,
    output logic        IorD,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSrc,
    output logic [2:0]  ALUControl,
    output logic        Retire,
    output logic        Illegal,
    output logic [15:0] Instr_Count,
    output logic [3:0]  State
);

    state_e      state_q, state_d;
    logic [15:0] count_q;

    alu_op_e     alu_op;
    logic        pc_write, branch;
    logic        ir_write_raw, mem_write_raw, reg_write_raw;
    logic        retire_raw, illegal_raw;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_FETCH;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (Retire) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = Mem_Ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = rtype_func_legal(Func) ? ST_RTEX : ST_ILLEGAL;
                    OP_BEQ:       state_d = ST_BEQEX;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JEX;
                    default:      state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR: state_d = (Opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  state_d = Mem_Ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  state_d = Mem_Ready ? ST_FETCH : ST_MEMWR;
            ST_RTEX:   state_d = ST_RTWB;
            ST_RTWB:   state_d = ST_FETCH;
            ST_BEQEX:  state_d = ST_FETCH;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_ADDIWB: state_d = ST_FETCH;
            ST_JEX:    state_d = ST_FETCH;
            ST_ILLEGAL: state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        retire_raw    = 1'b0;
        illegal_raw   = 1'b0;
        IorD          = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        PCSrc         = PCSRC_ALU;
        alu_op        = ALUOP_ADD;
        case (state_q)
            ST_FETCH: begin
                ALUSrcB      = SRCB_FOUR;
                ir_write_raw = Mem_Ready;
                pc_write     = Mem_Ready;
            end
            ST_DECODE: ALUSrcB = SRCB_IMM_SH2;
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_MEMRD: IorD = 1'b1;
            ST_MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            // The write strobe stays up through the whole wait; the access
            // retires only in the cycle memory accepts it.
            ST_MEMWR: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
                retire_raw    = Mem_Ready;
            end
            ST_RTEX: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNC;
            end
            ST_RTWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            ST_BEQEX: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_SUB;
                PCSrc      = PCSRC_ALUOUT;
                branch     = 1'b1;
                retire_raw = 1'b1;
            end
            ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_ADDIWB: begin
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            ST_JEX: begin
                PCSrc      = PCSRC_JUMP;
                pc_write   = 1'b1;
                retire_raw = 1'b1;
            end
            ST_ILLEGAL: illegal_raw = 1'b1;
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .func_i        (Func),
        .alu_control_o (ALUControl)
    );

    // Side-effecting strobes are gated by reset so an aborted instruction
    // cannot leave a partial write behind.
    assign PCEn        = RST & (pc_write | (branch & Zero));
    assign IRWrite     = RST & ir_write_raw;
    assign MemWrite    = RST & mem_write_raw;
    assign RegWrite    = RST & reg_write_raw;
    assign Retire      = RST & retire_raw;
    assign Illegal     = RST & illegal_raw;
    assign Instr_Count = count_q;
    assign State       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle vectors for the multicycle MIPS controller, plus a
// hand-written sw long-wait sequence and a FETCH stall sequence.
module tb_multicycle_controller;

    logic        CLK = 1'b0;
    logic        RST;
    logic [5:0]  Opcode, Func;
    logic        Zero, Mem_Ready;
    logic        PCEn, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [2:0]  ALUControl;
    logic        Retire, Illegal;
    logic [15:0] Instr_Count;
    logic [3:0]  State;

    always #5 CLK = ~CLK;

    multicycle_controller dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Func(Func), .Zero(Zero),
        .Mem_Ready(Mem_Ready), .PCEn(PCEn), .IorD(IorD), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .ALUControl(ALUControl), .Retire(Retire), .Illegal(Illegal),
        .Instr_Count(Instr_Count), .State(State)
    );

    // {PCEn,IorD,IRWrite,MemWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,ALUControl,Retire,Illegal}
    logic [16:0] act_ctrl;
    assign act_ctrl = {PCEn, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite,
                       ALUSrcA, ALUSrcB, PCSrc, ALUControl, Retire, Illegal};

    localparam logic [16:0] C_FETCH_RDY  = {7'b1010000, 1'b0, 2'b01, 2'b00, 3'b010, 2'b00};
    localparam logic [16:0] C_FETCH_WAIT = {7'b0000000, 1'b0, 2'b01, 2'b00, 3'b010, 2'b00};
    localparam logic [16:0] C_DECODE     = {7'b0000000, 1'b0, 2'b11, 2'b00, 3'b010, 2'b00};
    localparam logic [16:0] C_MEMADR     = {7'b0000000, 1'b1, 2'b10, 2'b00, 3'b010, 2'b00};
    localparam logic [16:0] C_MEMRD      = {7'b0100000, 1'b0, 2'b00, 2'b00, 3'b010, 2'b00};
    localparam logic [16:0] C_MEMWB      = {7'b0000011, 1'b0, 2'b00, 2'b00, 3'b010, 2'b10};
    localparam logic [16:0] C_MEMWR_WAIT = {7'b0101000, 1'b0, 2'b00, 2'b00, 3'b010, 2'b00};
    localparam logic [16:0] C_MEMWR_RDY  = {7'b0101000, 1'b0, 2'b00, 2'b00, 3'b010, 2'b10};
    localparam logic [16:0] C_RTEX_ADD   = {7'b0000000, 1'b1, 2'b00, 2'b00, 3'b010, 2'b00};
    localparam logic [16:0] C_RTEX_SUB   = {7'b0000000, 1'b1, 2'b00, 2'b00, 3'b110, 2'b00};
    localparam logic [16:0] C_RTEX_AND   = {7'b0000000, 1'b1, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [16:0] C_RTEX_OR    = {7'b0000000, 1'b1, 2'b00, 2'b00, 3'b001, 2'b00};
    localparam logic [16:0] C_RTEX_SLT   = {7'b0000000, 1'b1, 2'b00, 2'b00, 3'b111, 2'b00};
    localparam logic [16:0] C_RTWB       = {7'b0000101, 1'b0, 2'b00, 2'b00, 3'b010, 2'b10};
    localparam logic [16:0] C_BEQ_T      = {7'b1000000, 1'b1, 2'b00, 2'b01, 3'b110, 2'b10};
    localparam logic [16:0] C_BEQ_NT     = {7'b0000000, 1'b1, 2'b00, 2'b01, 3'b110, 2'b10};
    localparam logic [16:0] C_ADDIEX     = {7'b0000000, 1'b1, 2'b10, 2'b00, 3'b010, 2'b00};
    localparam logic [16:0] C_ADDIWB     = {7'b0000001, 1'b0, 2'b00, 2'b00, 3'b010, 2'b10};
    localparam logic [16:0] C_JEX        = {7'b1000000, 1'b0, 2'b00, 2'b10, 3'b010, 2'b10};
    localparam logic [16:0] C_ILL        = {7'b0000000, 1'b0, 2'b00, 2'b00, 3'b010, 2'b01};

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [3:0] st,
                       input logic [16:0] c, input logic [15:0] n);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.zero = z; v.rdy = rdy;
        v.st = st; v.ctrl = c; v.cnt = n;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    int mw_cycles, wr_cycles, ret_cycles, irw_seen;
    logic done;

    initial begin
        RST = 1'b0; Opcode = R; Func = F_ADD; Zero = 1'b0; Mem_Ready = 1'b1;

        // reset held low
        add(0, R,    F_ADD, 0, 1, 4'd0,  C_FETCH_WAIT, 16'd0);
        add(0, R,    F_ADD, 0, 1, 4'd0,  C_FETCH_WAIT, 16'd0);
        // add
        add(1, R,    F_ADD, 0, 1, 4'd0,  C_FETCH_RDY,  16'd0);
        add(1, R,    F_ADD, 0, 1, 4'd1,  C_DECODE,     16'd0);
        add(1, R,    F_ADD, 0, 1, 4'd6,  C_RTEX_ADD,   16'd0);
        add(1, R,    F_ADD, 0, 1, 4'd7,  C_RTWB,       16'd0);
        // lw, two wait cycles in MEMRD
        add(1, LW,   F_ADD, 0, 1, 4'd0,  C_FETCH_RDY,  16'd1);
        add(1, LW,   F_ADD, 0, 1, 4'd1,  C_DECODE,     16'd1);
        add(1, LW,   F_ADD, 0, 1, 4'd2,  C_MEMADR,     16'd1);
        add(1, LW,   F_ADD, 0, 0, 4'd3,  C_MEMRD,      16'd1);
        add(1, LW,   F_ADD, 0, 0, 4'd3,  C_MEMRD,      16'd1);
        add(1, LW,   F_ADD, 0, 1, 4'd3,  C_MEMRD,      16'd1);
        add(1, LW,   F_ADD, 0, 1, 4'd4,  C_MEMWB,      16'd1);
        // sw, one wait cycle in MEMWR
        add(1, SW,   F_ADD, 0, 1, 4'd0,  C_FETCH_RDY,  16'd2);
        add(1, SW,   F_ADD, 0, 1, 4'd1,  C_DECODE,     16'd2);
        add(1, SW,   F_ADD, 0, 1, 4'd2,  C_MEMADR,     16'd2);
        add(1, SW,   F_ADD, 0, 0, 4'd5,  C_MEMWR_WAIT, 16'd2);
        add(1, SW,   F_ADD, 0, 1, 4'd5,  C_MEMWR_RDY,  16'd2);
        // beq taken, then not taken
        add(1, BEQ,  F_ADD, 1, 1, 4'd0,  C_FETCH_RDY,  16'd3);
        add(1, BEQ,  F_ADD, 1, 1, 4'd1,  C_DECODE,     16'd3);
        add(1, BEQ,  F_ADD, 1, 1, 4'd8,  C_BEQ_T,      16'd3);
        add(1, BEQ,  F_ADD, 0, 1, 4'd0,  C_FETCH_RDY,  16'd4);
        add(1, BEQ,  F_ADD, 0, 1, 4'd1,  C_DECODE,     16'd4);
        add(1, BEQ,  F_ADD, 0, 1, 4'd8,  C_BEQ_NT,     16'd4);
        // illegal opcode, then illegal R-type Func
        add(1, 6'h3F, F_ADD, 0, 1, 4'd0, C_FETCH_RDY,  16'd5);
        add(1, 6'h3F, F_ADD, 0, 1, 4'd1, C_DECODE,     16'd5);
        add(1, 6'h3F, F_ADD, 0, 1, 4'd12, C_ILL,       16'd5);
        add(1, R,    6'h00, 0, 1, 4'd0,  C_FETCH_RDY,  16'd5);
        add(1, R,    6'h00, 0, 1, 4'd1,  C_DECODE,     16'd5);
        add(1, R,    6'h00, 0, 1, 4'd12, C_ILL,        16'd5);
        // j
        add(1, J,    F_ADD, 0, 1, 4'd0,  C_FETCH_RDY,  16'd5);
        add(1, J,    F_ADD, 0, 1, 4'd1,  C_DECODE,     16'd5);
        add(1, J,    F_ADD, 0, 1, 4'd11, C_JEX,        16'd5);
        // addi
        add(1, ADDI, F_ADD, 0, 1, 4'd0,  C_FETCH_RDY,  16'd6);
        add(1, ADDI, F_ADD, 0, 1, 4'd1,  C_DECODE,     16'd6);
        add(1, ADDI, F_ADD, 0, 1, 4'd9,  C_ADDIEX,     16'd6);
        add(1, ADDI, F_ADD, 0, 1, 4'd10, C_ADDIWB,     16'd6);
        // sub with one FETCH stall
        add(1, R,    F_SUB, 0, 0, 4'd0,  C_FETCH_WAIT, 16'd7);
        add(1, R,    F_SUB, 0, 1, 4'd0,  C_FETCH_RDY,  16'd7);
        add(1, R,    F_SUB, 0, 1, 4'd1,  C_DECODE,     16'd7);
        add(1, R,    F_SUB, 0, 1, 4'd6,  C_RTEX_SUB,   16'd7);
        add(1, R,    F_SUB, 0, 1, 4'd7,  C_RTWB,       16'd7);
        // and, or
        add(1, R,    F_AND, 0, 1, 4'd0,  C_FETCH_RDY,  16'd8);
        add(1, R,    F_AND, 0, 1, 4'd1,  C_DECODE,     16'd8);
        add(1, R,    F_AND, 0, 1, 4'd6,  C_RTEX_AND,   16'd8);
        add(1, R,    F_AND, 0, 1, 4'd7,  C_RTWB,       16'd8);
        add(1, R,    F_OR,  0, 1, 4'd0,  C_FETCH_RDY,  16'd9);
        add(1, R,    F_OR,  0, 1, 4'd1,  C_DECODE,     16'd9);
        add(1, R,    F_OR,  0, 1, 4'd6,  C_RTEX_OR,    16'd9);
        add(1, R,    F_OR,  0, 1, 4'd7,  C_RTWB,       16'd9);
        // slt aborted by reset in RTEX, then re-run to completion
        add(1, R,    F_SLT, 0, 1, 4'd0,  C_FETCH_RDY,  16'd10);
        add(1, R,    F_SLT, 0, 1, 4'd1,  C_DECODE,     16'd10);
        add(1, R,    F_SLT, 0, 1, 4'd6,  C_RTEX_SLT,   16'd10);
        add(0, R,    F_SLT, 0, 1, 4'd0,  C_FETCH_WAIT, 16'd0);
        add(0, R,    F_SLT, 0, 1, 4'd0,  C_FETCH_WAIT, 16'd0);
        add(1, R,    F_SLT, 0, 1, 4'd0,  C_FETCH_RDY,  16'd0);
        add(1, R,    F_SLT, 0, 1, 4'd1,  C_DECODE,     16'd0);
        add(1, R,    F_SLT, 0, 1, 4'd6,  C_RTEX_SLT,   16'd0);
        add(1, R,    F_SLT, 0, 1, 4'd7,  C_RTWB,       16'd0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            RST = vecs[i].rst; Opcode = vecs[i].op; Func = vecs[i].fn;
            Zero = vecs[i].zero; Mem_Ready = vecs[i].rdy;
            @(negedge CLK);
            chk($sformatf("v%0d state", i), {28'd0, State}, {28'd0, vecs[i].st});
            chk($sformatf("v%0d ctrl", i), {15'd0, act_ctrl}, {15'd0, vecs[i].ctrl});
            chk($sformatf("v%0d count", i), {16'd0, Instr_Count}, {16'd0, vecs[i].cnt});
            @(posedge CLK);
            #1;
        end

        // sw with three wait cycles: strobe for every MEMWR cycle, one retire
        Opcode = SW; Func = F_ADD; Zero = 1'b0;
        mw_cycles = 0; wr_cycles = 0; ret_cycles = 0; done = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            Mem_Ready = !(cyc >= 3 && cyc <= 5);
            @(negedge CLK);
            if (MemWrite) mw_cycles++;
            if (State == 4'd5) wr_cycles++;
            if (Retire) begin
                ret_cycles++;
                done = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        chk("sw_done", {31'd0, done}, 32'd1);
        chk("sw_memwrite_cycles", mw_cycles, 32'd4);
        chk("sw_memwr_state_cycles", wr_cycles, 32'd4);
        chk("sw_retire_cycles", ret_cycles, 32'd1);
        chk("sw_count", {16'd0, Instr_Count}, 32'd2);
        chk("sw_back_to_fetch", {28'd0, State}, 32'd0);

        // long FETCH stall: no IR load, no advance
        Opcode = J; Mem_Ready = 1'b0; irw_seen = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge CLK);
            if (IRWrite || PCEn) irw_seen++;
            @(posedge CLK);
            #1;
        end
        chk("stall_no_load", irw_seen, 32'd0);
        chk("stall_state", {28'd0, State}, 32'd0);
        Mem_Ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("stall_release", {28'd0, State}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
